// File: rtl/mc14500_prog_fetch.sv
// Program-store front end for the MC14500 core: loads DEPTH bytes from SPI NOR (READ 0x03) after reset, then serves them by PC.
// Latency: instr is registered, one clk_i after pc; ready/cpu_rst_n rise 2*(32+8*DEPTH)+2 cycles after reset release or reload.
// Backpressure: none; the core is held in reset until the image is loaded, and reload is ignored while a load is in progress.
module mc14500_prog_fetch #(
   parameter int          DEPTH      = 256,
   parameter int          AW         = 8,
   parameter logic [23:0] FLASH_BASE = 24'h000000
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        reload,
   input  logic [16:0] pc,
   output logic [7:0]  instr,
   output logic        ready,
   output logic        cpu_rst_n,
   output logic        spi_sclk,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   typedef enum logic [1:0] {CMD, ADDR, DATA, DONE} state_t;

   localparam logic [7:0] CMD_BYTE = 8'h03;

   state_t          state_q, state_d;
   logic [4:0]      bit_q, bit_d;       // bit position within the current field
   logic [AW-1:0]   idx_q;              // next program byte to write
   logic            ph_q;               // 1: in phase L, next edge raises SCLK
   logic [7:0]      shift_q;
   logic [7:0]      mem_q [DEPTH];
   logic            last_d;             // the bit ending now is the final data bit
   logic [7:0]      rx_byte;
   logic            in_range;

   logic            cs_n_q, sclk_q, mosi_q, ready_q, cpu_rst_n_q;
   logic [7:0]      instr_q;

   assign instr     = instr_q;
   assign ready     = ready_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign spi_sclk  = sclk_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_mosi  = mosi_q;

   assign rx_byte  = {shift_q[6:0], spi_miso};
   assign in_range = (pc >> AW) == 17'd0;

   // MOSI value for a given field bit, MSB first; data phase sends zeros.
   function automatic logic bit_of(input state_t st, input logic [4:0] b);
      logic v;
      v = 1'b0;
      case (st)
         CMD:     v = CMD_BYTE[3'(5'd7 - b)];
         ADDR:    v = FLASH_BASE[5'd23 - b];
         default: v = 1'b0;
      endcase
      return v;
   endfunction

   // Where the transfer goes after the bit currently in phase H completes.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q + 5'd1;
      last_d  = 1'b0;
      case (state_q)
         CMD: begin
            if (bit_q == 5'd7) begin
               state_d = ADDR;
               bit_d   = 5'd0;
            end
         end
         ADDR: begin
            if (bit_q == 5'd23) begin
               state_d = DATA;
               bit_d   = 5'd0;
            end
         end
         DATA: begin
            if (bit_q == 5'd7) begin
               bit_d = 5'd0;
               if (idx_q == AW'(DEPTH - 1)) begin
                  last_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Load sequencer, SPI bit engine and program-byte server.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q     <= CMD;
         bit_q       <= 5'd0;
         idx_q       <= '0;
         ph_q        <= 1'b0;
         shift_q     <= 8'h00;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         instr_q     <= 8'h00;
      end else begin
         case (state_q)
            DONE: begin
               if (reload) begin
                  state_q     <= CMD;
                  bit_q       <= 5'd0;
                  idx_q       <= '0;
                  ph_q        <= 1'b0;
                  shift_q     <= 8'h00;
                  cs_n_q      <= 1'b1;
                  sclk_q      <= 1'b0;
                  mosi_q      <= 1'b0;
                  ready_q     <= 1'b0;
                  cpu_rst_n_q <= 1'b0;
                  instr_q     <= 8'h00;
               end else begin
                  instr_q <= in_range ? mem_q[pc[AW-1:0]] : 8'h00;
               end
            end
            default: begin
               if (cs_n_q) begin
                  // Select the flash one cycle ahead of the first bit.
                  cs_n_q <= 1'b0;
               end else if (ph_q) begin
                  sclk_q <= 1'b1;
                  ph_q   <= 1'b0;
               end else if (!sclk_q) begin
                  // First bit after select: present it with SCLK low.
                  mosi_q <= bit_of(state_q, bit_q);
                  ph_q   <= 1'b1;
               end else begin
                  // End of phase H: sample MISO, then start the next bit or finish.
                  shift_q <= rx_byte;
                  sclk_q  <= 1'b0;
                  if (state_q == DATA && bit_q == 5'd7) begin
                     mem_q[idx_q] <= rx_byte;
                     idx_q        <= idx_q + AW'(1);
                  end
                  if (last_d) begin
                     state_q     <= DONE;
                     bit_q       <= 5'd0;
                     cs_n_q      <= 1'b1;
                     mosi_q      <= 1'b0;
                     ready_q     <= 1'b1;
                     cpu_rst_n_q <= 1'b1;
                  end else begin
                     state_q <= state_d;
                     bit_q   <= bit_d;
                     mosi_q  <= bit_of(state_d, bit_d);
                     ph_q    <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/mc14500_prog_fetch.md
Name: mc14500_prog_fetch

Overview:
- Program-store front end for the wrapped MC14500 core. It sits directly upstream of the core and drives the core's 8-bit instruction/address input.
- After reset it copies a program image from an external SPI NOR flash (READ 0x03) into an internal byte array.
- It holds the core in reset until the load completes.
- It then returns the program byte addressed by the core's 17-bit PC, with a registered output.

Parameters:
- DEPTH, 256, number of program bytes loaded and served. Power of two, 4..1024.
- AW, 8, log2(DEPTH).
- FLASH_BASE, 24'h000000, flash byte address of program byte 0.

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- reload  in  1  single-cycle pulse; restarts the load sequence (ignored while loading)
- pc  in  17  core program counter
- instr  out  8  program byte to core: [7:4] address nibble, [3:0] opcode
- ready  out  1  high once the image is loaded
- cpu_rst_n  out  1  core reset, active-low; low whenever not ready
- spi_sclk  out  1  flash clock, mode 0
- spi_cs_n  out  1  flash chip select
- spi_mosi  out  1  flash data in
- spi_miso  in  1  flash data out

Behaviour:
- Reset (rst_n low at a clk_i edge) sets: state=CMD, bit counter=0, byte index=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, ready=0, cpu_rst_n=0, instr=8'h00. Array contents are not reset.
- FSM states: CMD, ADDR, DATA, DONE.
  - CMD: 8 bits of 0x03.
  - ADDR: 24 bits of FLASH_BASE.
  - DATA: DEPTH*8 bits received.
  - DONE: serving.
- The first clk_i cycle after reset release asserts spi_cs_n=0.
- Bit timing: each SPI bit spans two clk_i cycles.
  - Phase L: spi_sclk=0, spi_mosi = current bit.
  - Phase H: spi_sclk=1.
  - spi_miso is sampled at the clk_i edge that ends phase H.
  - spi_sclk therefore runs at clk_i/2. All SPI outputs are registered.
- Bit order: MSB first for command, address and data.
- spi_mosi is 0 during DATA.
- Received bytes shift into a byte shift register. On the 8th sampled bit, the byte is written to array[byte index] and the index increments.
- After byte DEPTH-1 is written:
  - spi_cs_n=1 and spi_sclk=0 on the next cycle.
  - state=DONE; ready=1 and cpu_rst_n=1 on that same cycle.
  - No further SCLK edges occur.
- Total load time from reset release to ready=1 is 2*(32+8*DEPTH)+2 clk_i cycles. For DEPTH=4 this is 130.
- Serving (DONE):
  - instr <= array[pc[AW-1:0]] when pc[16:AW]==0; otherwise instr <= 8'h00.
  - Latency is one clk_i cycle. The core's PC changes at most every second clk_i, so instr is stable before the core samples it.
- While not DONE, instr=8'h00.
- reload in DONE: the next cycle returns to CMD with the same initial values as reset (ready=0, cpu_rst_n=0, spi_cs_n=0 on the following cycle), then runs the full sequence again. Array bytes are overwritten in place.
- reload while not in DONE has no effect.
- rst_n low mid-transfer: the next edge forces the reset values (spi_cs_n=1 aborts the flash command). The sequence restarts from CMD when rst_n returns high.
- cpu_rst_n is never high while rst_n is low: it is registered from the ready condition and is cleared in the same reset branch.
- pc wrap: pc=DEPTH-1 returns the last byte. pc=DEPTH returns 8'h00 (out of range), not byte 0.

Test Plan:
- Basic load, DEPTH=4, FLASH_BASE=24'h001000, flash model holding A5 3C 0F F0 at 0x1000:
  - MOSI carries 0x03 00 10 00 over the first 32 SCLK rising edges.
  - ready rises exactly 130 cycles after rst_n high.
  - pc=0..3 -> instr A5,3C,0F,F0 one cycle later.
- Out of range: pc=4, then pc=17'h10000 -> instr 00 both times. pc=3 -> F0.
- Hold-off: sample cpu_rst_n every cycle during the load -> 0 throughout, 1 from the same cycle as ready. instr=00 while ready=0.
- Mid-load reset: drop rst_n for one cycle at cycle 60 -> spi_cs_n=1 and spi_sclk=0 the next cycle. A fresh 0x03 command follows release. Load completes 130 cycles after release with correct data.
- Reload: in DONE, change the flash image to 11 22 33 44 and pulse reload -> ready=0 and cpu_rst_n=0 the next cycle, a second full transfer runs, then pc=2 -> 33. A reload pulse during that transfer is ignored (total time is still 130 cycles).
- Timing check: across the whole load, spi_mosi changes only while spi_sclk=0, and exactly 8*(4+DEPTH)=64 SCLK rising edges occur per load.
